// File: rtl/alu_scheduler.sv
// Two-requester ALU front end: round-robin grant in IDLE, one-cycle execute,
// then the response is held until the consumer takes it.
module alu_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [1:0]       req0_opcode,
  input  logic [1:0]       req1_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_last_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic             w_any_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_alu;

  // Under contention the requester that did not own the last response wins.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_id : req1_valid;
  assign w_accept    = (r_state == S_IDLE) && w_any_valid;
  assign w_rsp_fire  = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_valid) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are forced to their reset values during the reset cycle itself.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      req0_ready = w_accept && !w_grant_id;
      req1_ready = w_accept && w_grant_id;
      busy       = (r_state != S_IDLE);
    end
  end

  assign rsp_valid  = r_rsp_valid & ~rst;
  assign rsp_id     = r_rsp_id & ~rst;
  assign rsp_result = rst ? '0 : r_rsp_result;
  assign rsp_zero   = r_rsp_zero & ~rst;

  always_comb begin
    case (r_op)
      2'b00:   w_alu = r_a + r_b;
      2'b01:   w_alu = r_a - r_b;
      2'b10:   w_alu = r_a & r_b;
      default: w_alu = r_a | r_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id    <= 1'b1;
      r_op         <= 2'b00;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_id <= w_grant_id;
        r_op <= w_grant_id ? req1_opcode : req0_opcode;
        r_a  <= w_grant_id ? req1_a : req0_a;
        r_b  <= w_grant_id ? req1_b : req0_b;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= w_alu;
        r_rsp_zero   <= (w_alu == '0);
      end
      if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_last_id   <= r_rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed vector table, hand sequences for
// backpressure and mid-operation reset, then random traffic against a model.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_opcode, req1_opcode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [7:0] rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  typedef struct {
    bit       v0;
    bit       v1;
    bit [1:0] op0;
    bit [7:0] a0;
    bit [7:0] b0;
    bit [1:0] op1;
    bit [7:0] a1;
    bit [7:0] b1;
    bit       exp_id;
    bit [7:0] exp_res;
    bit       exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_opcode = 0; req1_opcode = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_result"}, int'(rsp_result), 0);
    chk({tag, "_rsp_zero"}, int'(rsp_zero), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready0"}, int'(req0_ready), 0);
    chk({tag, "_ready1"}, int'(req1_ready), 0);
  endtask

  // Applies one request from IDLE and walks it through grant, latency and handshake.
  task automatic run_vec(input vec_t v, input int idx);
    req0_valid = v.v0; req0_opcode = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_opcode = v.op1; req1_a = v.a1; req1_b = v.b1;
    rsp_ready = 0;
    #1;
    chk("vec_ready0", int'(req0_ready), int'(!v.exp_id));
    chk("vec_ready1", int'(req1_ready), int'(v.exp_id));
    step();
    req0_valid = 0; req1_valid = 0;
    chk("vec_n1_rsp_valid", int'(rsp_valid), 0);
    chk("vec_n1_busy", int'(busy), 1);
    step();
    chk("vec_n2_rsp_valid", int'(rsp_valid), 1);
    chk("vec_rsp_id", int'(rsp_id), int'(v.exp_id));
    chk("vec_rsp_result", int'(rsp_result), int'(v.exp_res));
    chk("vec_rsp_zero", int'(rsp_zero), int'(v.exp_zero));
    $display("vec %0d: id=%0d result=%02h zero=%0d", idx, rsp_id, rsp_result, rsp_zero);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("vec_post_rsp_valid", int'(rsp_valid), 0);
    chk("vec_post_busy", int'(busy), 0);
  endtask

  initial begin
    bit m_pending, m_last, m_exp_id, exp_grant, exp_gid, exp_rv;
    int m_age, m_exp_res;
    vec_t v;

    vecs[0] = '{1, 1, 2'd2, 8'hF0, 8'h3C, 2'd3, 8'h0F, 8'h30, 0, 8'h30, 0};
    vecs[1] = '{1, 1, 2'd2, 8'hF0, 8'h3C, 2'd3, 8'h0F, 8'h30, 1, 8'h3F, 0};
    vecs[2] = '{1, 1, 2'd2, 8'hF0, 8'h3C, 2'd3, 8'h0F, 8'h30, 0, 8'h30, 0};
    vecs[3] = '{1, 0, 2'd0, 8'h0F, 8'h01, 2'd0, 8'h00, 8'h00, 0, 8'h10, 0};
    vecs[4] = '{0, 1, 2'd0, 8'h00, 8'h00, 2'd0, 8'hFF, 8'h01, 1, 8'h00, 1};
    vecs[5] = '{0, 1, 2'd0, 8'h00, 8'h00, 2'd1, 8'h00, 8'h01, 1, 8'hFF, 0};
    vecs[6] = '{1, 0, 2'd1, 8'h05, 8'h05, 2'd0, 8'h00, 8'h00, 0, 8'h00, 1};
    vecs[7] = '{0, 1, 2'd0, 8'h00, 8'h00, 2'd3, 8'hA0, 8'h05, 1, 8'hA5, 0};

    // Reset with both requesters asserting: nothing may be granted.
    idle_inputs();
    rst = 1;
    req0_valid = 1; req1_valid = 1;
    step();
    step();
    check_reset_outputs("reset");
    rst = 0;
    req0_valid = 0; req1_valid = 0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: response held for 5 cycles while requesters keep asking.
    req0_valid = 1; req0_opcode = 2'd1; req0_a = 8'h05; req0_b = 8'h07;
    #1;
    chk("bp_accept", int'(req0_ready), 1);
    step();
    req0_valid = 0;
    step();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_id", int'(rsp_id), 0);
      chk("bp_rsp_result", int'(rsp_result), 8'hFE);
      chk("bp_rsp_zero", int'(rsp_zero), 0);
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
      chk("bp_busy", int'(busy), 1);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    rsp_ready = 1;
    #1;
    chk("bp_hs_ready0", int'(req0_ready), 0);
    step();
    rsp_ready = 0;
    chk("bp_after_rsp_valid", int'(rsp_valid), 0);
    chk("bp_after_busy", int'(busy), 0);
    $display("backpressure: id=0 result=fe held 5 cycles");

    // Reset pulsed while the operation is in EXEC.
    req0_valid = 1; req0_opcode = 2'd0; req0_a = 8'h01; req0_b = 8'h01;
    step();
    req0_valid = 0;
    rst = 1;
    #1;
    check_reset_outputs("rst_cycle");
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      check_reset_outputs("after_rst");
      step();
    end
    v = '{0, 1, 2'd0, 8'h00, 8'h00, 2'd2, 8'hAA, 8'h0F, 1, 8'h0A, 0};
    run_vec(v, 8);

    // Random traffic against a transaction-level model.
    rst = 1;
    step();
    rst = 0;
    m_pending = 0; m_last = 1; m_age = 0; m_exp_id = 0; m_exp_res = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req0_valid  = ($urandom_range(0, 9) < 6);
      req1_valid  = ($urandom_range(0, 9) < 6);
      req0_opcode = 2'($urandom_range(0, 3));
      req1_opcode = 2'($urandom_range(0, 3));
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        req0_b = req0_a; req1_b = req1_a;
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      exp_grant = !m_pending && (req0_valid || req1_valid);
      exp_gid   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      exp_rv    = m_pending && (m_age >= 2);
      chk("rnd_ready0", int'(req0_ready), int'(exp_grant && !exp_gid));
      chk("rnd_ready1", int'(req1_ready), int'(exp_grant && exp_gid));
      chk("rnd_rsp_valid", int'(rsp_valid), int'(exp_rv));
      chk("rnd_busy", int'(busy), int'(m_pending));
      if (exp_rv) begin
        chk("rnd_rsp_id", int'(rsp_id), int'(m_exp_id));
        chk("rnd_rsp_result", int'(rsp_result), m_exp_res);
        chk("rnd_rsp_zero", int'(rsp_zero), int'(m_exp_res == 0));
        if (rsp_ready) begin
          $display("rnd cyc %0d: id=%0d result=%02h", cyc, rsp_id, rsp_result);
          m_last = m_exp_id;
          m_pending = 0;
        end else begin
          m_age++;
        end
      end else if (m_pending) begin
        m_age++;
      end
      if (exp_grant) begin
        m_pending = 1;
        m_age     = 1;
        m_exp_id  = exp_gid;
        m_exp_res = exp_gid ? alu_ref(int'(req1_opcode), int'(req1_a), int'(req1_b))
                            : alu_ref(int'(req0_opcode), int'(req0_a), int'(req0_b));
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_opcode / req1_opcode  input  2 each  00 add, 01 sub, 10 and, 11 or.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-008 The block SHALL have port rsp_valid  output  1  response available.
REQ-009 The block SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-010 The block SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 The block SHALL have port rsp_result  output  WIDTH  ALU result.
REQ-012 The block SHALL have port rsp_zero  output  1  1 when rsp_result is all zeros.
REQ-013 The block SHALL have port busy  output  1  1 whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 In IDLE with at least one reqN_valid high, the block SHALL grant exactly one requester, assert that requester's reqN_ready combinationally in the same cycle, capture its opcode, operands and id, and move to EXEC.
REQ-016 Arbitration SHALL be round-robin: with both valid, the winner is the requester not granted most recently; with one valid, that requester wins.
REQ-017 Both reqN_ready SHALL be 0 in EXEC and RESP, and in IDLE when the corresponding reqN_valid is 0.
REQ-018 In EXEC the block SHALL compute the ALU function on the captured values, register rsp_result, rsp_zero and rsp_id, assert rsp_valid, and move to RESP.
REQ-019 Add and sub SHALL be modulo 2^WIDTH; carry and borrow are discarded. And/or SHALL be bitwise.
REQ-020 rsp_zero SHALL equal 1 exactly when the registered result equals zero.
REQ-021 Latency: a request accepted in cycle N SHALL produce rsp_valid high from cycle N+2.
REQ-022 In RESP, rsp_valid, rsp_id, rsp_result and rsp_zero SHALL hold stable until rsp_ready is high.
REQ-023 On rsp_valid and rsp_ready both high, the block SHALL deassert rsp_valid on the next cycle, update the round-robin pointer to rsp_id, and return to IDLE.
REQ-024 A new request SHALL NOT be accepted in the cycle a response handshake completes; acceptance resumes in the following IDLE cycle, so minimum spacing is 3 cycles per operation.
REQ-025 reqN_valid changes while the block is not in IDLE SHALL have no effect on the state.

Reset
REQ-026 While rst is high the block SHALL enter IDLE and drive rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, busy=0, req0_ready=0, req1_ready=0.
REQ-027 Reset SHALL set the round-robin pointer so that requester 0 wins the first contended grant.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response for it is ever produced.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-030 Single request: req0 with opcode 00, a=8'h0F, b=8'h01 accepted in cycle N -> rsp_valid in cycle N+2, rsp_result=8'h10, rsp_zero=0, rsp_id=0.
REQ-031 Wrap and zero: req1 with opcode 00, a=8'hFF, b=8'h01 -> rsp_result=8'h00, rsp_zero=1, rsp_id=1; opcode 01, a=8'h00, b=8'h01 -> 8'hFF, zero 0.
REQ-032 Contention: both valid with req0 opcode 10 (8'hF0, 8'h3C) and req1 opcode 11 (8'h0F, 8'h30) held from reset -> first response id 0 with 8'h30, then id 1 with 8'h3F; repeated contention alternates ids.
REQ-033 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, both reqN_ready 0; rsp_ready=1 -> rsp_valid 0 next cycle, busy 0.
REQ-034 Reset mid-operation: rst pulsed for one cycle in EXEC -> no rsp_valid afterwards, all outputs at reset values, next req1 request served normally.
